// File: rtl/mix_columns_engine_if.sv
// Handshake bundle between an AES datapath stage and the MixColumns engine.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
interface mix_columns_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // Upstream/downstream side that feeds states in and takes results out
  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Engine side
  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns on one 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: out_valid rises BUSY_CYCLES edges after the input handshake edge.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there, 0 while BUSY.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mix_columns_engine_if.slave bus_if
);

  localparam int BUSY_CYCLES = 4 / COLS_PER_CYCLE;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic [127:0] src_q, src_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_o;
  logic [127:0] work_next;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // Transform one 32-bit column; byte 0 is the MSB. Inverse coefficients
  // 09/0b/0d/0e are assembled from the x2/x4/x8 chain by XOR only.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [1:0]  i0, i1, i2, i3;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[2'(i)]  = col[31-8*i -: 8];
      x2[2'(i)] = xtime(a[2'(i)]);
      x4[2'(i)] = xtime(x2[2'(i)]);
      x8[2'(i)] = xtime(x4[2'(i)]);
      m3[2'(i)] = x2[2'(i)] ^ a[2'(i)];
      m9[2'(i)] = x8[2'(i)] ^ a[2'(i)];
      mb[2'(i)] = x8[2'(i)] ^ x2[2'(i)] ^ a[2'(i)];
      md[2'(i)] = x8[2'(i)] ^ x4[2'(i)] ^ a[2'(i)];
      me[2'(i)] = x8[2'(i)] ^ x4[2'(i)] ^ x2[2'(i)];
    end
    for (int r = 0; r < 4; r++) begin
      // Each output row is the coefficient row rotated right by r.
      i0 = 2'(r);
      i1 = i0 + 2'd1;
      i2 = i0 + 2'd2;
      i3 = i0 + 2'd3;
      if (inv) begin
        res[31-8*r -: 8] = me[i0] ^ mb[i1] ^ md[i2] ^ m9[i3];
      end else begin
        res[31-8*r -: 8] = x2[i0] ^ m3[i1] ^ a[i2] ^ a[i3];
      end
    end
    return res;
  endfunction

  // Work register with this cycle's column slice transformed in place.
  always_comb begin
    int idx;
    idx       = 0;
    work_next = work_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      idx = int'(cnt_q) * COLS_PER_CYCLE + j;
      work_next[127-32*idx -: 32] = mix_col(src_q[127-32*idx -: 32], mode_q);
    end
  end

  // Next-state, handshake and datapath-capture decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    src_d       = src_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (bus_if.in_valid) begin
          src_d   = bus_if.in_data;
          mode_d  = bus_if.in_inv;
          cnt_d   = 2'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        work_d = work_next;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'(BUSY_CYCLES - 1)) begin
          // Publish the full state only once every column is done.
          out_data_d  = work_next;
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // A new state may enter in the same cycle the result leaves.
        in_ready_o = bus_if.out_ready;
        if (bus_if.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (bus_if.in_valid) begin
            src_d   = bus_if.in_data;
            mode_d  = bus_if.in_inv;
            cnt_d   = 2'd0;
            state_d = S_BUSY;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        cnt_d       = 2'd0;
      end
    endcase
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      mode_q      <= 1'b0;
      src_q       <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_if.in_ready  = in_ready_o;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances with COLS_PER_CYCLE = 4, 2, 1.
// Results are compared against a GF(2^8) shift-and-add matrix model.
// Output backpressure is driven explicitly by the scenario tasks.
module tb_mix_columns_engine;

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BP_IN   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] BP_OUT  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid_v;
  logic [2:0]   in_inv_v;
  logic [2:0]   out_ready_v;
  logic [127:0] in_data_a [3];
  wire  [2:0]   in_ready_v;
  wire  [2:0]   out_valid_v;
  wire  [127:0] out_data_a [3];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance g uses COLS_PER_CYCLE 4, 2, 1 for g = 0, 1, 2
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine_if u_if ();
    assign u_if.in_valid  = in_valid_v[g];
    assign u_if.in_inv    = in_inv_v[g];
    assign u_if.in_data   = in_data_a[g];
    assign u_if.out_ready = out_ready_v[g];
    assign in_ready_v[g]  = u_if.in_ready;
    assign out_valid_v[g] = u_if.out_valid;
    assign out_data_a[g]  = u_if.out_data;
    mix_columns_engine #(.COLS_PER_CYCLE(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (u_if.slave)
    );
  end

  function automatic int busy_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 2 : 4);
  endfunction

  // Plain shift-and-add multiplication in GF(2^8)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant coefficient at distance d from the diagonal
  function automatic logic [7:0] coef(input logic inv, input int d);
    case (d)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    logic [7:0]   acc;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef(inv, (k - r + 4) % 4), s[127-32*c-8*k -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  // Offer one state, wait for acceptance and then for out_valid (bounded).
  // lat = edges from acceptance to out_valid, or -1 on timeout.
  task automatic send(input int idx, input logic [127:0] d, input logic inv,
                      output int lat, output bit rdy_in_busy);
    int t;
    lat = -1;
    rdy_in_busy = 1'b0;
    in_data_a[idx]  = d;
    in_inv_v[idx]   = inv;
    in_valid_v[idx] = 1'b1;
    t = 0;
    while (!in_ready_v[idx] && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready_v[idx]) begin
      in_valid_v[idx] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
    in_data_a[idx]  = {$urandom, $urandom, $urandom, $urandom};
    in_inv_v[idx]   = 1'($urandom);
    t = 0;
    while (!out_valid_v[idx] && t < 20) begin
      if (in_ready_v[idx]) rdy_in_busy = 1'b1;
      @(posedge clk); #1; t++;
    end
    if (out_valid_v[idx]) lat = t;
  endtask

  task automatic drain(input int idx);
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid_v[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got=%b want=0", i, out_valid_v[i]); end
      checks++;
      if (out_data_a[i] !== 128'h0) begin errors++; $display("FAIL reset_out_data[%0d] got=%h want=0", i, out_data_a[i]); end
      checks++;
      if (in_ready_v[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got=%b want=1", i, in_ready_v[i]); end
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid_v[i] !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid[%0d] got=%b want=0", i, out_valid_v[i]); end
    end
  endtask

  task automatic test_vectors();
    int lat;
    bit rb;
    for (int i = 0; i < 3; i++) begin
      send(i, FWD_IN, 1'b0, lat, rb);
      checks++;
      if (lat !== busy_of(i)) begin errors++; $display("FAIL fwd_latency[%0d] got=%0d want=%0d", i, lat, busy_of(i)); end
      checks++;
      if (rb !== 1'b0) begin errors++; $display("FAIL fwd_in_ready_busy[%0d] got=%b want=0", i, rb); end
      checks++;
      if (out_data_a[i] !== FWD_OUT) begin errors++; $display("FAIL fwd_data[%0d] got=%h want=%h", i, out_data_a[i], FWD_OUT); end
      drain(i);
      send(i, FWD_OUT, 1'b1, lat, rb);
      checks++;
      if (lat !== busy_of(i)) begin errors++; $display("FAIL inv_latency[%0d] got=%0d want=%0d", i, lat, busy_of(i)); end
      checks++;
      if (out_data_a[i] !== FWD_IN) begin errors++; $display("FAIL inv_data[%0d] got=%h want=%h", i, out_data_a[i], FWD_IN); end
      drain(i);
      checks++;
      if (out_valid_v[i] !== 1'b0) begin errors++; $display("FAIL inv_valid_clear[%0d] got=%b want=0", i, out_valid_v[i]); end
    end
  endtask

  task automatic test_random();
    int lat;
    bit rb;
    logic [127:0] d, exp;
    logic inv;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 6; n++) begin
        d   = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom);
        exp = ref_mix(d, inv);
        send(i, d, inv, lat, rb);
        checks++;
        if (lat !== busy_of(i)) begin errors++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, busy_of(i)); end
        checks++;
        if (out_data_a[i] !== exp) begin errors++; $display("FAIL rand_data[%0d] inv=%b got=%h want=%h", i, inv, out_data_a[i], exp); end
        drain(i);
        checks++;
        if (out_data_a[i] !== exp) begin errors++; $display("FAIL rand_hold_after_pop[%0d] got=%h want=%h", i, out_data_a[i], exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, t;
    bit rb;
    send(0, FWD_IN, 1'b0, lat, rb);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL bp_first_latency got=%0d want=1", lat); end
    in_data_a[0]  = BP_IN;
    in_inv_v[0]   = 1'b0;
    in_valid_v[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid_v[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, out_valid_v[0]); end
      checks++;
      if (out_data_a[0] !== FWD_OUT) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", c, out_data_a[0], FWD_OUT); end
      checks++;
      if (in_ready_v[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, in_ready_v[0]); end
      @(posedge clk); #1;
    end
    out_ready_v[0] = 1'b1;
    #1;
    checks++;
    if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL bp_passthrough_ready got=%b want=1", in_ready_v[0]); end
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b0;
    in_data_a[0]   = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%b want=0", out_valid_v[0]); end
    t = 0;
    while (!out_valid_v[0] && t < 20) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t !== 1) begin errors++; $display("FAIL bp_second_latency got=%0d want=1", t); end
    checks++;
    if (out_data_a[0] !== BP_OUT) begin errors++; $display("FAIL bp_second_data got=%h want=%h", out_data_a[0], BP_OUT); end
    drain(0);
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bit rb;
    logic [127:0] d;
    checks++;
    if (in_ready_v[2] !== 1'b1) begin errors++; $display("FAIL rmb_idle_ready got=%b want=1", in_ready_v[2]); end
    in_data_a[2]  = FWD_IN;
    in_inv_v[2]   = 1'b0;
    in_valid_v[2] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[2] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (in_ready_v[2] !== 1'b0) begin errors++; $display("FAIL rmb_busy_ready got=%b want=0", in_ready_v[2]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_v[2] !== 1'b0) begin errors++; $display("FAIL rmb_out_valid got=%b want=0", out_valid_v[2]); end
    checks++;
    if (out_data_a[2] !== 128'h0) begin errors++; $display("FAIL rmb_out_data got=%h want=0", out_data_a[2]); end
    checks++;
    if (in_ready_v[2] !== 1'b1) begin errors++; $display("FAIL rmb_in_ready got=%b want=1", in_ready_v[2]); end
    #3 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_v[2] !== 1'b0) begin errors++; $display("FAIL rmb_no_partial cyc=%0d got=%b want=0", c, out_valid_v[2]); end
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    send(2, d, 1'b1, lat, rb);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rmb_after_latency got=%0d want=4", lat); end
    checks++;
    if (out_data_a[2] !== ref_mix(d, 1'b1)) begin errors++; $display("FAIL rmb_after_data got=%h want=%h", out_data_a[2], ref_mix(d, 1'b1)); end
    drain(2);
  endtask

  task automatic test_mode_latch();
    int t;
    in_data_a[2]  = FWD_IN;
    in_inv_v[2]   = 1'b0;
    in_valid_v[2] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[2] = 1'b0;
    t = 0;
    while (!out_valid_v[2] && t < 20) begin
      in_inv_v[2] = ~in_inv_v[2];
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t !== 4) begin errors++; $display("FAIL latch_latency got=%0d want=4", t); end
    checks++;
    if (out_data_a[2] !== FWD_OUT) begin errors++; $display("FAIL latch_data got=%h want=%h", out_data_a[2], FWD_OUT); end
    drain(2);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_v  = '0;
    in_inv_v    = '0;
    out_ready_v = '0;
    for (int i = 0; i < 3; i++) in_data_a[i] = '0;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    test_mode_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
